hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core; the producer side of the operand-forwarding path.
- Generates stall/flush controls for load-use hazards, taken branches/jumps and data-memory wait states.
- Owns the post-writeback holding register whose outputs (temp_rd_addr, temp_reg_write, temp_data) feed the forwarding unit's third source.
- Keeps stall/flush event counters and a data-memory timeout watchdog.

---
 rtl/core_pkg.sv | 13 +
 rtl/hazard_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register-address width, the x0 constant and the
// hazard controller state type.
package core_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] X0 = '0;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: an EX load whose rd is read by the instruction in ID.
module hazard_detect
   import core_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_mem_read,
   output logic                  load_use
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
      rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
      // x0 is hardwired, so a load targeting it never produces a dependency
      load_use = ex_mem_read && (ex_rd_addr != X0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, post-writeback holding
// register for forwarding, event counters and a data-memory wait watchdog.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_mem_read,
   input  logic                  ex_redirect,
   input  logic                  mem_access,
   input  logic                  dmem_ready,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr,
   input  logic                  wb_reg_write,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  pc_stall,
   output logic                  if_id_stall,
   output logic                  if_id_flush,
   output logic                  id_ex_stall,
   output logic                  id_ex_flush,
   output logic                  ex_mem_stall,
   output logic                  mem_wb_flush,
   output logic [REG_ADDR_W-1:0] temp_rd_addr,
   output logic                  temp_reg_write,
   output logic [XLEN-1:0]       temp_data,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   localparam bit          WD_EN = (MEM_TIMEOUT != 0);
   localparam int unsigned WC_W  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WC_W-1:0] TO_LAST = WC_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   hz_state_t       state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
   logic            load_use;
   logic            timeout_rel;
   logic            mem_wait;
   logic            redirect_flush;

   hazard_detect u_detect (
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd_addr  (ex_rd_addr),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = '0;
      pc_stall       = 1'b0;
      if_id_stall    = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_stall    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_stall   = 1'b0;
      mem_wb_flush   = 1'b0;
      redirect_flush = 1'b0;

      timeout_rel = WD_EN && (state == MEM_WAIT) && !dmem_ready && (wait_cnt == TO_LAST);
      mem_wait    = mem_access && !dmem_ready && !timeout_rel;

      unique case (state)
         RUN: begin
            if (mem_access && !dmem_ready) state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (dmem_ready || timeout_rel) state_nxt = RUN;
            else                           wait_cnt_nxt = wait_cnt + 1'b1;
         end
         default: state_nxt = RUN;
      endcase

      // A redirect seen during a memory wait is not consumed here; EX is frozen,
      // so it is still presented once the wait ends and is acted on then.
      if (mem_wait) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush    = 1'b1;
         id_ex_flush    = 1'b1;
         redirect_flush = 1'b1;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= RUN;
         wait_cnt       <= '0;
         temp_rd_addr   <= '0;
         temp_reg_write <= 1'b0;
         temp_data      <= '0;
         mem_timeout    <= 1'b0;
         stall_cycles   <= '0;
         flush_count    <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (!ex_mem_stall) begin
            temp_rd_addr   <= wb_rd_addr;
            temp_reg_write <= wb_reg_write;
            temp_data      <= wb_data;
         end
         if (timeout_rel)    mem_timeout  <= 1'b1;
         if (pc_stall)       stall_cycles <= stall_cycles + 1'b1;
         if (redirect_flush) flush_count  <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr, wb_rd_addr;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
   logic        mem_access, dmem_ready, wb_reg_write;
   logic [31:0] wb_data;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic        ex_mem_stall, mem_wb_flush, temp_reg_write, mem_timeout;
   logic [4:0]  temp_rd_addr;
   logic [31:0] temp_data, stall_cycles, flush_count;

   hazard_ctrl #(.XLEN(32), .CNT_W(32), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_redirect(ex_redirect), .mem_access(mem_access),
      .dmem_ready(dmem_ready), .wb_rd_addr(wb_rd_addr),
      .wb_reg_write(wb_reg_write), .wb_data(wb_data),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
      .temp_rd_addr(temp_rd_addr), .temp_reg_write(temp_reg_write),
      .temp_data(temp_data), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] cyc;
      logic [6:0]  ctl;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
      logic        to;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // behavioural model state
   bit          m_wait;
   int          m_cnt;
   logic [4:0]  m_rd;
   logic        m_we;
   logic [31:0] m_data;
   logic        m_to;
   logic [31:0] m_sc, m_fc;

   task automatic idle();
      id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rd_addr = 0; ex_mem_read = 0; ex_redirect = 0;
      mem_access = 0; dmem_ready = 0;
      wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
   endtask

   task automatic model_reset();
      m_wait = 0; m_cnt = 0; m_rd = 0; m_we = 0; m_data = 0;
      m_to = 0; m_sc = 0; m_fc = 0;
   endtask

   // One cycle: predict this cycle's outputs, queue them, advance the model.
   task automatic step();
      exp_t e;
      bit   tmo, mw, lu, rf, lus;
      tmo = m_wait && (m_cnt == TO - 1) && !dmem_ready;
      mw  = mem_access && !dmem_ready && !tmo;
      lu  = ex_mem_read && (ex_rd_addr != 0) &&
            ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
             (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
      rf  = !mw && ex_redirect;
      lus = !mw && !ex_redirect && lu;
      e.cyc  = cyc;
      e.ctl  = {mw || lus, mw || lus, rf, mw, rf || lus, mw, mw};
      e.rd   = m_rd;
      e.we   = m_we;
      e.data = m_data;
      e.to   = m_to;
      e.sc   = m_sc;
      e.fc   = m_fc;
      exp_q.push_back(e);

      if (rst) begin
         model_reset();
      end else begin
         if (mw || lus) m_sc = m_sc + 1;
         if (rf)        m_fc = m_fc + 1;
         if (!mw) begin
            m_rd = wb_rd_addr; m_we = wb_reg_write; m_data = wb_data;
         end
         if (!m_wait) begin
            if (mem_access && !dmem_ready) begin m_wait = 1; m_cnt = 0; end
         end else if (dmem_ready) begin
            m_wait = 0; m_cnt = 0;
         end else if (tmo) begin
            m_wait = 0; m_cnt = 0; m_to = 1;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp, input logic [31:0] c);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, c, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("ctl", 32'({pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                         id_ex_flush, ex_mem_stall, mem_wb_flush}), 32'(e.ctl), e.cyc);
         chk("temp_rd_addr", 32'(temp_rd_addr), 32'(e.rd), e.cyc);
         chk("temp_reg_write", 32'(temp_reg_write), 32'(e.we), e.cyc);
         chk("temp_data", temp_data, e.data, e.cyc);
         chk("mem_timeout", 32'(mem_timeout), 32'(e.to), e.cyc);
         chk("stall_cycles", stall_cycles, e.sc, e.cyc);
         chk("flush_count", flush_count, e.fc, e.cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      idle();
      rst = 1;
      @(posedge clk); #1;
      model_reset();

      step();                                   // reset state
      rst = 0;

      wb_rd_addr = 9; wb_reg_write = 1; wb_data = 32'h1234_5678;
      step();
      idle(); step();                           // temp shows x9

      ex_mem_read = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_uses_rs2 = 1;
      step();                                   // load-use stall
      idle(); step();
      ex_mem_read = 1; ex_rd_addr = 0; id_rs2_addr = 0; id_uses_rs2 = 1;
      step();                                   // x0: no hazard
      ex_rd_addr = 5; id_rs2_addr = 5; id_uses_rs2 = 0;
      step();                                   // operand unused: no hazard
      id_uses_rs2 = 1; ex_redirect = 1;
      step();                                   // redirect beats load-use
      idle(); step();

      wb_rd_addr = 7; wb_reg_write = 1; wb_data = 32'hDEAD_BEEF;
      step();
      wb_rd_addr = 3; wb_data = 32'h0BAD_F00D; mem_access = 1; ex_redirect = 1;
      repeat (3) step();                        // wait; redirect frozen
      dmem_ready = 1; step();
      idle(); step();

      mem_access = 1;
      repeat (TO + 2) step();                   // watchdog release
      idle(); repeat (3) step();

      mem_access = 1;
      repeat (2) step();
      rst = 1; step();                          // reset during MEM_WAIT
      rst = 0; idle(); step();

      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 299) == 0);
         id_rs1_addr  = 5'($urandom_range(0, 3));
         id_rs2_addr  = 5'($urandom_range(0, 3));
         id_uses_rs1  = 1'($urandom_range(0, 1));
         id_uses_rs2  = 1'($urandom_range(0, 1));
         ex_rd_addr   = 5'($urandom_range(0, 3));
         ex_mem_read  = 1'($urandom_range(0, 1));
         ex_redirect  = ($urandom_range(0, 5) == 0);
         mem_access   = ($urandom_range(0, 2) == 0);
         dmem_ready   = ($urandom_range(0, 2) != 0);
         wb_rd_addr   = 5'($urandom);
         wb_reg_write = 1'($urandom_range(0, 1));
         wb_data      = $urandom;
         step();
      end
      idle(); rst = 0;

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain actual=%0d expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
